// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - packet ingress controller steering bytes into three destination FIFOs
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous active-high reset
//   pkt_valid    high on header/payload bytes, low on the trailing parity byte
//   data_in      packet byte; header [7:2]=payload length, [1:0]=destination
//   fifo_empty   per-destination FIFO empty flags
//   fifo_full    per-destination FIFO full flags
//   soft_reset   per-destination abort request
//   dout         byte written to the selected FIFO
//   write_enb    one-hot FIFO write strobe
//   lfd_state    high while the header byte is written
//   busy         upstream stall; data_in is consumed only when low
//   parity_done  one-cycle pulse when a packet completes
//   err          parity/length error flag, held until the next accepted header
module router_ingress_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] fifo_full,
    input  logic [2:0] soft_reset,
    output logic [7:0] dout,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic       parity_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_DECODE       = 3'd0,
        S_WAIT_EMPTY   = 3'd1,
        S_LOAD_HEADER  = 3'd2,
        S_LOAD_DATA    = 3'd3,
        S_CHECK_PARITY = 3'd4,
        S_DROP         = 3'd5
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr;
    logic [7:0] hdr;
    logic [7:0] calc_parity;
    logic [7:0] pkt_parity;
    logic [6:0] count;

    logic [2:0] addr_oh;
    logic [2:0] hdr_oh;
    logic       sel_empty;
    logic       sel_full;
    logic       new_empty;
    logic       in_pkt;
    logic       abort;

    // Destination selects are built as one-hot masks so destination 3
    // simply selects nothing instead of indexing past the flag vectors.
    assign addr_oh   = 3'b001 << addr;
    assign hdr_oh    = 3'b001 << data_in[1:0];
    assign sel_empty = |(fifo_empty & addr_oh);
    assign sel_full  = |(fifo_full & addr_oh);
    assign new_empty = |(fifo_empty & hdr_oh);

    // Only the latched destination's soft_reset matters, and only while a
    // packet is being moved toward or into its FIFO; CHECK_PARITY is immune.
    assign in_pkt = (state == S_WAIT_EMPTY) || (state == S_LOAD_HEADER) || (state == S_LOAD_DATA);
    assign abort  = in_pkt && |(soft_reset & addr_oh);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_DECODE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_DECODE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) begin
                        next_state = S_DROP;
                    end else if (new_empty) begin
                        next_state = S_LOAD_HEADER;
                    end else begin
                        next_state = S_WAIT_EMPTY;
                    end
                end
            end
            S_WAIT_EMPTY: begin
                if (abort) begin
                    next_state = pkt_valid ? S_DROP : S_DECODE;
                end else if (sel_empty) begin
                    next_state = S_LOAD_HEADER;
                end
            end
            S_LOAD_HEADER: begin
                if (abort) begin
                    next_state = pkt_valid ? S_DROP : S_DECODE;
                end else begin
                    next_state = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: begin
                if (abort) begin
                    next_state = pkt_valid ? S_DROP : S_DECODE;
                end else if (!sel_full && !pkt_valid) begin
                    next_state = S_CHECK_PARITY;
                end
            end
            S_CHECK_PARITY: next_state = S_DECODE;
            S_DROP: begin
                if (!pkt_valid) begin
                    next_state = S_DECODE;
                end
            end
            default: next_state = S_DECODE;
        endcase
    end

    // Outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        dout        = 8'h00;
        write_enb   = 3'b000;
        lfd_state   = 1'b0;
        busy        = 1'b0;
        parity_done = 1'b0;
        if (!reset) begin
            case (state)
                S_WAIT_EMPTY: busy = 1'b1;
                S_LOAD_HEADER: begin
                    busy = 1'b1;
                    if (!abort) begin
                        dout      = hdr;
                        write_enb = addr_oh;
                        lfd_state = 1'b1;
                    end
                end
                S_LOAD_DATA: begin
                    busy = sel_full;
                    if (!sel_full && !abort) begin
                        dout      = data_in;
                        write_enb = addr_oh;
                    end
                end
                S_CHECK_PARITY: begin
                    busy        = 1'b1;
                    parity_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Packet datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            addr        <= 2'd0;
            hdr         <= 8'h00;
            calc_parity <= 8'h00;
            pkt_parity  <= 8'h00;
            count       <= 7'd0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    if (pkt_valid && (data_in[1:0] != 2'd3)) begin
                        hdr         <= data_in;
                        addr        <= data_in[1:0];
                        calc_parity <= data_in;
                        count       <= 7'd0;
                        err         <= 1'b0;
                    end
                end
                S_LOAD_DATA: begin
                    if (!abort && !sel_full) begin
                        if (pkt_valid) begin
                            calc_parity <= calc_parity ^ data_in;
                            if (count != 7'd127) begin
                                count <= count + 7'd1;
                            end
                        end else begin
                            pkt_parity <= data_in;
                        end
                    end
                end
                S_CHECK_PARITY: begin
                    err <= (calc_parity != pkt_parity) || (count != {1'b0, hdr[7:2]});
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb/tb_router_ingress_ctrl.sv - randomized self-checking bench for router_ingress_ctrl
module tb_router_ingress_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_full;
    logic [2:0] soft_reset;
    logic [7:0] dout;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic       busy;
    logic       parity_done;
    logic       err;

    always #5 clock = ~clock;

    router_ingress_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .soft_reset  (soft_reset),
        .dout        (dout),
        .write_enb   (write_enb),
        .lfd_state   (lfd_state),
        .busy        (busy),
        .parity_done (parity_done),
        .err         (err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] wq[$];
    int          pd_cnt = 0;
    logic        exp_err = 1'b0;
    logic [7:0]  bq[$];
    int          stall_at = -1;
    bit          rnd = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled at negedge: log every write, and require silence otherwise.
    task automatic monitor();
        if (write_enb != 3'b000) begin
            wq.push_back({write_enb, dout, lfd_state});
            check("onehot", $countones(write_enb), 1);
        end else begin
            check("idle_dout", dout, 0);
            check("idle_lfd", lfd_state, 0);
        end
        if (parity_done) pd_cnt++;
    endtask

    task automatic cyc(input logic pv, input logic [7:0] d, input logic [2:0] fe,
                       input logic [2:0] ff, input logic [2:0] sr);
        @(posedge clock);
        #1;
        pkt_valid  = pv;
        data_in    = d;
        fifo_empty = fe;
        fifo_full  = ff;
        soft_reset = sr;
        @(negedge clock);
        monitor();
    endtask

    task automatic make_pkt(input int dest, input int len, input int npay, input bit par_ok);
        logic [7:0] h;
        logic [7:0] x;
        logic [7:0] b;
        bq.delete();
        h = {len[5:0], dest[1:0]};
        bq.push_back(h);
        x = h;
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            x = x ^ b;
        end
        bq.push_back(par_ok ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    // Upstream driver: presents bq[idx] and advances only when busy is low.
    task automatic feed(input int start, input int stop);
        int idx;
        int guard;
        int st;
        logic [2:0] fe;
        logic [2:0] ff;
        bit stalling;
        idx = start;
        guard = 0;
        st = 0;
        while (idx < stop && guard < 2000) begin
            stalling = (idx == stall_at) && (st < 3);
            if (stalling) begin
                ff = 3'b111;
                st++;
            end else begin
                ff = (rnd && $urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            end
            fe = rnd ? 3'($urandom_range(0, 7)) : 3'b111;
            cyc(idx != bq.size() - 1, bq[idx], fe, ff, 3'b000);
            if (stalling) begin
                check("stall_busy", busy, 1);
                check("stall_we", write_enb, 0);
            end
            if (!busy) idx++;
            guard++;
        end
        check("feed_timeout", guard < 2000, 1);
        if (stop == bq.size()) begin
            repeat (3) cyc(1'b0, 8'($urandom), 3'b111, 3'b000, 3'b000);
        end
    endtask

    // Reference model: a completed packet is header+payload+parity to one
    // destination; destination 3 produces nothing and leaves err alone.
    task automatic check_pkt(input string tag);
        logic [7:0]  h;
        logic [7:0]  x;
        logic [2:0]  oh;
        logic [11:0] exp_q[$];
        int          n;
        int          m;
        h = bq[0];
        n = bq.size();
        if (h[1:0] == 2'd3) begin
            check({tag, "_pd"}, pd_cnt, 0);
        end else begin
            oh = 3'b001 << h[1:0];
            x = h;
            exp_q.push_back({oh, h, 1'b1});
            for (int i = 1; i < n - 1; i++) begin
                exp_q.push_back({oh, bq[i], 1'b0});
                x = x ^ bq[i];
            end
            exp_q.push_back({oh, bq[n-1], 1'b0});
            exp_err = (x != bq[n-1]) || ((n - 2) != int'(h[7:2]));
            check({tag, "_pd"}, pd_cnt, 1);
        end
        check({tag, "_nwr"}, wq.size(), exp_q.size());
        m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_wr"}, wq[i], exp_q[i]);
        end
        check({tag, "_err"}, err, exp_err);
        wq.delete();
        pd_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'($urandom);
        fifo_empty = 3'b111;
        fifo_full  = 3'b000;
        soft_reset = 3'b000;
        @(negedge clock);
        check("rst_dout", dout, 0);
        check("rst_we", write_enb, 0);
        check("rst_lfd", lfd_state, 0);
        check("rst_busy", busy, 0);
        check("rst_pd", parity_done, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_err", err, 0);
        check("rst_we2", write_enb, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        pkt_valid = 1'b0;
        wq.delete();
        pd_cnt  = 0;
        exp_err = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_empty = 3'b111;
        fifo_full  = 3'b000;
        soft_reset = 3'b000;
        do_reset();

        // Basic packet, then bad parity, then the error clears on a new header.
        bq = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        feed(0, bq.size());
        check_pkt("basic");
        bq = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        feed(0, bq.size());
        check_pkt("badpar");
        check("badpar_set", err, 1);
        bq = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        feed(0, bq.size());
        check_pkt("clear");

        // Destination FIFO not empty: stall on the header until it drains.
        bq = {8'h0A, 8'h01, 8'h02, 8'h09};
        cyc(1'b1, 8'h0A, 3'b011, 3'b000, 3'b000);
        check("dec_busy", busy, 0);
        repeat (3) begin
            cyc(1'b1, 8'h01, 3'b011, 3'b000, 3'b000);
            check("wait_busy", busy, 1);
        end
        cyc(1'b1, 8'h01, 3'b111, 3'b000, 3'b000);
        check("wait_busy2", busy, 1);
        check("wait_nowr", wq.size(), 0);
        cyc(1'b1, 8'h01, 3'b111, 3'b000, 3'b000);
        check("hdr_we", write_enb, 3'b100);
        check("hdr_dout", dout, 8'h0A);
        check("hdr_lfd", lfd_state, 1);
        feed(1, bq.size());
        check_pkt("wait");

        // Full FIFO for three cycles mid-payload.
        make_pkt(0, 4, 4, 1'b1);
        stall_at = 2;
        feed(0, bq.size());
        stall_at = -1;
        check_pkt("stall");

        // Invalid destination is dropped without touching err.
        bq = {8'h07, 8'h55, 8'h52};
        feed(0, bq.size());
        check_pkt("drop");
        make_pkt(2, 0, 0, 1'b1);
        feed(0, bq.size());
        check_pkt("len0");

        // Soft reset on the active destination mid-payload; other bits ignored.
        bq = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000);
        cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b000);
        cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b101);
        check("sr_other_we", write_enb, 3'b010);
        cyc(1'b1, 8'h22, 3'b111, 3'b000, 3'b010);
        check("sr_we", write_enb, 0);
        cyc(1'b1, 8'h33, 3'b111, 3'b000, 3'b000);
        check("sr_drop_busy", busy, 0);
        cyc(1'b0, 8'h0D, 3'b111, 3'b000, 3'b000);
        repeat (2) cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000);
        check("sr_nwr", wq.size(), 2);
        if (wq.size() == 2) begin
            check("sr_wr0", wq[0], {3'b010, 8'h0D, 1'b1});
            check("sr_wr1", wq[1], {3'b010, 8'h11, 1'b0});
        end
        check("sr_pd", pd_cnt, 0);
        check("sr_err", err, 0);
        wq.delete();
        pd_cnt = 0;
        exp_err = 1'b0;
        make_pkt(1, 3, 3, 1'b1);
        feed(0, bq.size());
        check_pkt("after_sr");

        // Reset mid-packet: err cleared even though a drop would keep it.
        make_pkt(0, 2, 2, 1'b0);
        feed(0, bq.size());
        check_pkt("pre_rst");
        make_pkt(3, 4, 4, 1'b1);
        feed(0, 2);
        do_reset();
        make_pkt(1, 5, 5, 1'b1);
        feed(0, 3);
        do_reset();
        make_pkt(1, 5, 5, 1'b1);
        feed(0, bq.size());
        check_pkt("post_rst");

        // Randomized packets against the model.
        rnd = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int dest;
            int len;
            int npay;
            dest = $urandom_range(0, 3);
            len  = $urandom_range(0, 12);
            npay = len;
            if ($urandom_range(0, 5) == 0) npay = (len == 0) ? 1 : len - 1;
            make_pkt(dest, len, npay, $urandom_range(0, 3) != 0);
            feed(0, bq.size());
            check_pkt("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/router_ingress_ctrl.md
ROUTER_INGRESS_CTRL -- requirements
Module: router_ingress_ctrl

Interface
REQ-001 Parameters: none; three destination FIFOs, 8-bit bytes, fixed.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pkt_valid  in  1  high for header/payload bytes; low on the parity byte.
REQ-005 data_in  in  8  packet byte; header [7:2]=payload length (0-63), [1:0]=destination (0-2; 3 invalid).
REQ-006 fifo_empty  in  3  per-destination FIFO empty flags.
REQ-007 fifo_full  in  3  per-destination FIFO full flags.
REQ-008 soft_reset  in  3  per-destination abort request.
REQ-009 dout  out  8  byte to FIFOs.
REQ-010 write_enb  out  3  one-hot FIFO write strobe.
REQ-011 lfd_state  out  1  high only while the header is being written.
REQ-012 busy  out  1  upstream stall; data_in is consumed at an edge only when busy=0.
REQ-013 parity_done  out  1  one-cycle pulse at packet completion.
REQ-014 err  out  1  parity/length error flag.

Function
REQ-015 States: DECODE, WAIT_EMPTY, LOAD_HEADER, LOAD_DATA, CHECK_PARITY, DROP; state, addr, hdr, calc_parity, pkt_parity and count are registered.
REQ-016 dout, write_enb, lfd_state and busy are combinational from state, latched addr and inputs; dout=0 and write_enb=0 whenever no write occurs.
REQ-017 DECODE, busy=0, pkt_valid=1, data_in[1:0]<3: latch hdr=data_in, addr=data_in[1:0], calc_parity=data_in, count=0, err=0; go to LOAD_HEADER if fifo_empty[addr], else WAIT_EMPTY.
REQ-018 DECODE, pkt_valid=1, data_in[1:0]=3: header consumed and discarded, go to DROP, err unchanged.
REQ-019 DECODE, pkt_valid=0: data_in ignored, stay.
REQ-020 WAIT_EMPTY: busy=1; go to LOAD_HEADER on the first cycle fifo_empty[addr]=1.
REQ-021 LOAD_HEADER: busy=1, lfd_state=1, dout=hdr, write_enb[addr]=1 for exactly one cycle; then LOAD_DATA.
REQ-022 LOAD_DATA: busy=fifo_full[addr]; while busy=1, write_enb=0 and data_in is not consumed (held by upstream).
REQ-023 LOAD_DATA, busy=0, pkt_valid=1: dout=data_in, write_enb[addr]=1, calc_parity^=data_in, count+1 saturating at 127 (7-bit).
REQ-024 LOAD_DATA, busy=0, pkt_valid=0: parity byte written like a payload byte, pkt_parity=data_in, calc_parity not updated, go to CHECK_PARITY.
REQ-025 Length 0 legal: first LOAD_DATA byte then has pkt_valid=0 and is the parity byte.
REQ-026 CHECK_PARITY: busy=1, parity_done=1 for this cycle only; err set next edge if calc_parity!=pkt_parity or count!=hdr[7:2]; go to DECODE.
REQ-027 err holds until the next valid header is accepted (REQ-017) or reset.
REQ-028 DROP: busy=0, write_enb=0; consume bytes until one with pkt_valid=0 is consumed, then DECODE.
REQ-029 soft_reset[addr]=1 in WAIT_EMPTY, LOAD_HEADER, LOAD_DATA: write_enb=0 that cycle, no err/parity_done; go to DROP if pkt_valid=1, else DECODE. soft_reset bits for other destinations are ignored.
REQ-030 soft_reset in CHECK_PARITY has no effect; CHECK_PARITY always completes.
REQ-031 Exactly hdr[7:2]+2 writes per completed packet, all to one destination, header first with lfd_state=1.

Reset
REQ-032 reset=1 at an edge: state=DECODE, hdr=0, addr=0, calc_parity=0, pkt_parity=0, count=0, err=0; overrides all other inputs, including mid-packet.
REQ-033 During and after reset: dout=0, write_enb=0, lfd_state=0, busy=0, parity_done=0.

Verification
REQ-034 fifo_empty=3'b111, bytes 0x0D,0x11,0x22,0x33 (pkt_valid=1) then 0x0D (pkt_valid=0) -> write_enb=3'b010 for 5 cycles, dout 0x0D,0x11,0x22,0x33,0x0D, lfd_state only on the first, parity_done pulse, err=0.
REQ-035 Same packet with parity 0x00 -> err=1 after CHECK_PARITY; next valid header clears err.
REQ-036 fifo_empty[2]=0, header 0x0A -> busy=1 and no writes until fifo_empty[2]=1, then 0x0A written to write_enb=3'b100 with lfd_state=1 one cycle later.
REQ-037 fifo_full[0]=1 for 3 cycles mid-payload -> busy=1, write_enb=0; held byte written exactly once when full drops; payload order preserved, err=0.
REQ-038 Header 0x07, payload 0x55, parity 0x52 -> write_enb stays 0, DROP for 2 cycles, back to DECODE, err=0.
REQ-039 soft_reset[1] in LOAD_DATA with pkt_valid=1 -> write_enb=0 that cycle, DROP until pkt_valid=0 byte, no parity_done; reset mid-packet -> DECODE, all outputs 0.
